platform_dwell_ctrl: RTL and testbench

Parametrised successor of the platform-to-down enable logic in the S3200 motion path. It measures platform dwell time in microseconds and asserts a down-enable once a programmable dwell threshold is met. The threshold is selected per print-head type and per PRINT-to-DOWN path. It sits between the print-sequence state decoder (st_req_* / st_platform) and the Z-axis down-move controller.

---
 rtl/platform_dwell_ctrl_pkg.sv | 16 +
 rtl/platform_dwell_ctrl_if.sv | 30 +++
 rtl/platform_dwell_ctrl_us_tick_gen.sv | 24 ++
 rtl/platform_dwell_ctrl.sv | 89 ++++++++
 tb/tb_platform_dwell_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/platform_dwell_ctrl_pkg.sv
// platform_dwell_pkg: shared state encoding and default settings for the platform dwell controller.
package platform_dwell_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        READY
    } state_t;

    localparam int         DEF_CLK_PER_US    = 96;
    localparam int         DEF_TIME_LONG_US  = 300;
    localparam int         DEF_TIME_SHORT_US = 100;
    localparam logic [7:0] DEF_FAST_TYPE_A   = 8'h05;
    localparam logic [7:0] DEF_FAST_TYPE_B   = 8'h06;

endpackage

// File: rtl/platform_dwell_ctrl_if.sv
// platform_dwell_ctrl_if: sequencer-side inputs and down-move outputs of the dwell controller.
interface platform_dwell_ctrl_if #(
    parameter int US_W   = 10,
    parameter int TYPE_W = 8
);
    logic [TYPE_W-1:0] printhead_type;
    logic [TYPE_W-1:0] fast_type_a;
    logic [TYPE_W-1:0] fast_type_b;
    logic [US_W-1:0]   time_long_us;
    logic [US_W-1:0]   time_short_us;
    logic              st_req_print;
    logic              st_req_down;
    logic              st_platform;
    logic              ptodown_en;
    logic              ptodown_pulse;
    logic [US_W-1:0]   dwell_us;
    logic              path_fast;

    modport master (
        output printhead_type, fast_type_a, fast_type_b, time_long_us, time_short_us,
        output st_req_print, st_req_down, st_platform,
        input  ptodown_en, ptodown_pulse, dwell_us, path_fast
    );

    modport slave (
        input  printhead_type, fast_type_a, fast_type_b, time_long_us, time_short_us,
        input  st_req_print, st_req_down, st_platform,
        output ptodown_en, ptodown_pulse, dwell_us, path_fast
    );
endinterface

// File: rtl/platform_dwell_ctrl_us_tick_gen.sv
// us_tick_gen: one-cycle tick every CLK_PER_US enabled cycles; count held at 0 while disabled.
module us_tick_gen #(
    parameter int CLK_PER_US = 96
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int            CW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/platform_dwell_ctrl.sv
// platform_dwell_ctrl: measures platform dwell in microseconds and enables the Z down-move
// once the threshold chosen for the head type and PRINT-to-DOWN path is reached.
module platform_dwell_ctrl
    import platform_dwell_pkg::*;
#(
    parameter int CLK_PER_US = DEF_CLK_PER_US,
    parameter int US_W       = 10,
    parameter int TYPE_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    platform_dwell_ctrl_if.slave  bus
);
    localparam logic [US_W-1:0] DWELL_MAX = '1;

    state_t            state_q, state_d;
    logic              p_q, p_d;
    logic [US_W-1:0]   dwell_q, dwell_d;
    logic [US_W-1:0]   thr_q, thr_d;
    logic              fast_q, fast_d;
    logic              en_q, en_d;
    logic              pulse_q, pulse_d;
    logic              tick;
    logic              fast_sel;
    logic [US_W-1:0]   thr_sel;
    logic [TYPE_W-1:0] ptype;

    us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.st_platform),
        .tick (tick)
    );

    assign ptype = bus.printhead_type;

    always_comb begin
        p_d      = bus.st_req_print ? 1'b1 : bus.st_req_down ? 1'b0 : p_q;
        fast_sel = p_d && (ptype == bus.fast_type_a || ptype == bus.fast_type_b);
        thr_sel  = fast_sel ? bus.time_short_us : bus.time_long_us;
        dwell_d  = !bus.st_platform ? '0 :
                   (tick && dwell_q != DWELL_MAX) ? dwell_q + 1'b1 : dwell_q;
        state_d  = state_q;
        thr_d    = thr_q;
        fast_d   = fast_q;
        // Leaving the platform phase overrides every other transition.
        if (!bus.st_platform) begin
            state_d = IDLE;
            fast_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = (thr_sel == '0) ? READY : DWELL;
                    thr_d   = thr_sel;
                    fast_d  = fast_sel;
                end
                DWELL:   state_d = (dwell_q >= thr_q) ? READY : DWELL;
                default: state_d = READY;
            endcase
        end
        en_d    = (state_d == READY);
        pulse_d = (state_d == READY) && (state_q != READY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= 1'b0;
            dwell_q <= '0;
            thr_q   <= '0;
            fast_q  <= 1'b0;
            en_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            dwell_q <= dwell_d;
            thr_q   <= thr_d;
            fast_q  <= fast_d;
            en_q    <= en_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.ptodown_en    = en_q;
    assign bus.ptodown_pulse = pulse_q;
    assign bus.dwell_us      = dwell_q;
    assign bus.path_fast     = fast_q;
endmodule

// File: tb/tb_platform_dwell_ctrl.sv
// tb_platform_dwell_ctrl: directed and random stimulus scored against a cycle-count model of dwell timing.
module tb_platform_dwell_ctrl;
    import platform_dwell_pkg::*;

    localparam int CPU    = 4;
    localparam int US_W   = 10;
    localparam int TYPE_W = 8;
    localparam int MAXD   = (1 << US_W) - 1;

    typedef struct {
        int    en;
        int    pulse;
        int    dwell;
        int    fast;
        string tag;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst;
    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    int m       = 0;
    int mthr    = 0;
    bit p       = 0;
    bit mfast   = 0;
    bit en_prev = 0;

    always #5 clk = ~clk;

    platform_dwell_ctrl_if #(.US_W(US_W), .TYPE_W(TYPE_W)) bus ();

    platform_dwell_ctrl #(.CLK_PER_US(CPU), .US_W(US_W), .TYPE_W(TYPE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cmp(string name, int act, int exp, string tag);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%s] t=%0t got %0d expected %0d", name, tag, $time, act, exp);
        end
    endtask

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Expected outputs follow from m = number of consecutive edges with st_platform sampled high.
    task automatic model_edge();
        exp_t e;
        int   en;
        if (rst) begin
            p = 0; m = 0; en_prev = 0; mfast = 0;
            e = '{0, 0, 0, 0, phase};
        end else begin
            p = bus.st_req_print ? 1'b1 : bus.st_req_down ? 1'b0 : p;
            if (bus.st_platform) begin
                m++;
                if (m == 1) begin
                    mfast = p && (bus.printhead_type == bus.fast_type_a || bus.printhead_type == bus.fast_type_b);
                    mthr  = mfast ? int'(bus.time_short_us) : int'(bus.time_long_us);
                end
            end else m = 0;
            en = (m >= 1 && min_i((m - 1) / CPU, MAXD) >= mthr) ? 1 : 0;
            e  = '{en, (en == 1 && !en_prev) ? 1 : 0, (m == 0) ? 0 : min_i(m / CPU, MAXD), (m >= 1 && mfast) ? 1 : 0, phase};
            en_prev = (en == 1);
        end
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("ptodown_en", int'(bus.ptodown_en), e.en, e.tag);
            cmp("ptodown_pulse", int'(bus.ptodown_pulse), e.pulse, e.tag);
            cmp("dwell_us", int'(bus.dwell_us), e.dwell, e.tag);
            cmp("path_fast", int'(bus.path_fast), e.fast, e.tag);
        end
    end

    task automatic pulse_req(bit pr, bit dn);
        bus.st_platform  = 1'b0;
        bus.st_req_print = pr;
        bus.st_req_down  = dn;
        step();
        bus.st_req_print = 1'b0;
        bus.st_req_down  = 1'b0;
    endtask

    task automatic drop();
        bus.st_platform = 1'b0;
        step();
    endtask

    initial begin
        logic [TYPE_W-1:0] types [4] = '{8'h01, 8'h05, 8'h06, 8'h02};
        rst = 1'b1;
        bus.printhead_type = 8'h01;
        bus.fast_type_a    = DEF_FAST_TYPE_A;
        bus.fast_type_b    = DEF_FAST_TYPE_B;
        bus.time_long_us   = 10'd3;
        bus.time_short_us  = 10'd1;
        bus.st_req_print   = 1'b0;
        bus.st_req_down    = 1'b0;
        bus.st_platform    = 1'b0;
        step();
        step();
        cmp("reset_en", int'(bus.ptodown_en), 0, phase);
        cmp("reset_dwell", int'(bus.dwell_us), 0, phase);
        rst = 1'b0;

        phase = "normal";
        pulse_req(1'b0, 1'b1);
        bus.st_platform = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 12) begin
                cmp("normal_dwell@12", int'(bus.dwell_us), 3, phase);
                cmp("normal_en@12", int'(bus.ptodown_en), 0, phase);
            end
            if (i == 13) begin
                cmp("normal_en@13", int'(bus.ptodown_en), 1, phase);
                cmp("normal_pulse@13", int'(bus.ptodown_pulse), 1, phase);
                cmp("normal_fast", int'(bus.path_fast), 0, phase);
            end
            if (i == 14) cmp("normal_pulse@14", int'(bus.ptodown_pulse), 0, phase);
        end
        drop();
        cmp("drop_en", int'(bus.ptodown_en), 0, phase);
        cmp("drop_dwell", int'(bus.dwell_us), 0, phase);

        phase = "fast";
        pulse_req(1'b1, 1'b0);
        bus.printhead_type = 8'h05;
        bus.st_platform    = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 4) cmp("fast_en@4", int'(bus.ptodown_en), 0, phase);
            if (i == 5) begin
                cmp("fast_en@5", int'(bus.ptodown_en), 1, phase);
                cmp("fast_path", int'(bus.path_fast), 1, phase);
            end
        end
        drop();
        cmp("fast_path_cleared", int'(bus.path_fast), 0, phase);

        phase = "slow_type";
        bus.printhead_type = 8'h02;
        bus.st_platform    = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 12) cmp("type02_en@12", int'(bus.ptodown_en), 0, phase);
            if (i == 13) cmp("type02_en@13", int'(bus.ptodown_en), 1, phase);
        end
        drop();

        phase = "both_req";
        pulse_req(1'b0, 1'b1);
        pulse_req(1'b1, 1'b1);
        bus.printhead_type = 8'h06;
        bus.st_platform    = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) cmp("both_fast", int'(bus.path_fast), 1, phase);
        end
        drop();

        phase = "mid_change";
        pulse_req(1'b0, 1'b1);
        bus.printhead_type = 8'h01;
        bus.st_platform    = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 6) bus.time_long_us = 10'd10;
            if (i == 12) cmp("mid_en@12", int'(bus.ptodown_en), 0, phase);
            if (i == 13) cmp("mid_en@13", int'(bus.ptodown_en), 1, phase);
        end
        drop();

        phase = "zero_thr";
        bus.time_long_us = 10'd0;
        bus.st_platform  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i == 1) begin
                cmp("zero_en@1", int'(bus.ptodown_en), 1, phase);
                cmp("zero_pulse@1", int'(bus.ptodown_pulse), 1, phase);
            end
        end
        drop();
        bus.time_long_us = 10'd3;

        phase = "glitch";
        bus.st_platform = 1'b1;
        repeat (7) step();
        drop();
        bus.st_platform = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 12) cmp("glitch_en@12", int'(bus.ptodown_en), 0, phase);
            if (i == 13) cmp("glitch_en@13", int'(bus.ptodown_en), 1, phase);
        end
        drop();

        phase = "reset_mid";
        pulse_req(1'b1, 1'b0);
        bus.printhead_type = 8'h05;
        bus.st_platform    = 1'b1;
        repeat (6) step();
        rst = 1'b1;
        step();
        cmp("rst_en", int'(bus.ptodown_en), 0, phase);
        cmp("rst_pulse", int'(bus.ptodown_pulse), 0, phase);
        cmp("rst_dwell", int'(bus.dwell_us), 0, phase);
        cmp("rst_fast", int'(bus.path_fast), 0, phase);
        rst = 1'b0;
        drop();

        phase = "saturate";
        bus.printhead_type = 8'h01;
        bus.time_long_us   = 10'd15;
        bus.st_platform    = 1'b1;
        repeat ((MAXD + 80) * CPU) step();
        cmp("sat_dwell", int'(bus.dwell_us), MAXD, phase);
        cmp("sat_en", int'(bus.ptodown_en), 1, phase);
        drop();

        phase = "random";
        for (int i = 0; i < 4000; i++) begin
            rst                = ($urandom_range(0, 299) == 0);
            bus.st_platform    = ($urandom_range(0, 39) != 0);
            bus.st_req_print   = ($urandom_range(0, 15) == 0);
            bus.st_req_down    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) bus.printhead_type = types[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) bus.time_long_us = 10'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) bus.time_short_us = 10'($urandom_range(0, 3));
            step();
        end
        rst = 1'b0;

        @(negedge clk);
        #1;
        cmp("scoreboard_drained", sb.size(), 0, "end");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
